imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words sequentially from address 0 and verifies a trailing XOR checksum.
- Holds the CPU core in reset until a load completes successfully.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_loader_word_assembler.sv | 38 +++
 rtl/imem_loader.sv | 103 ++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory, fetch stage and boot loader.
// The default ADDR_W lives here so that memory depth agrees everywhere.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_ADDR_W    = 8;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes into a little-endian instruction word. word_done flags
// the 4th byte combinationally, and word is the completed value in that cycle.
module word_assembler
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane_p0;
  logic [WORD_W-1:0] shreg_p0;

  assign word      = {byte_data, shreg_p0[WORD_W-1:8]};
  assign word_done = byte_vld && (lane_p0 == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lane_p0 <= '0;
    else if (clr)
      lane_p0 <= '0;
    else if (byte_vld)
      lane_p0 <= lane_p0 + LANE_W'(1);
  end

  // stage p0: byte shift register, fully overwritten every four bytes
  always_ff @(posedge clk) begin
    if (byte_vld)
      shreg_p0 <= {byte_data, shreg_p0[WORD_W-1:8]};
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: count byte, 4N little-endian data bytes,
// XOR checksum byte. The core stays in reset until a load verifies.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);

  state_e            state_p0, state_nxt;
  logic [ADDR_W-1:0] last_idx_p0;
  logic [ADDR_W-1:0] word_idx_p0;
  logic [7:0]        xor_p0;
  logic              accept, data_acc, start_acc, restart_ok;
  logic              word_done;
  logic [WORD_W-1:0] asm_word;

  assign in_ready   = (state_p0 == IDLE) || (state_p0 == DATA) || (state_p0 == CHECK);
  assign accept     = in_valid && in_ready;
  assign start_acc  = accept && (state_p0 == IDLE);
  assign data_acc   = accept && (state_p0 == DATA);
  assign restart_ok = restart_i && ((state_p0 == DONE) || (state_p0 == ERR));

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_acc),
    .byte_vld  (data_acc),
    .byte_data (in_data),
    .word      (asm_word),
    .word_done (word_done)
  );

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:     if (accept) state_nxt = DATA;
      DATA:     if (word_done && (word_idx_p0 == last_idx_p0)) state_nxt = CHECK;
      CHECK:    if (accept) state_nxt = (in_data == xor_p0) ? DONE : ERR;
      DONE, ERR: if (restart_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // stage p0: status outputs are decoded from the next state so they land
  // in the same cycle as the state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0    <= IDLE;
      last_idx_p0 <= '0;
      word_idx_p0 <= '0;
      xor_p0      <= '0;
      we_o        <= 1'b0;
      waddr_o     <= '0;
      wdata_o     <= '0;
      cpu_rst_o   <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      words_o     <= '0;
    end else begin
      state_p0  <= state_nxt;
      we_o      <= word_done;
      done_o    <= (state_nxt == DONE);
      err_o     <= (state_nxt == ERR);
      cpu_rst_o <= (state_nxt != DONE);

      if (start_acc) begin
        last_idx_p0 <= in_data[ADDR_W-1:0];
        word_idx_p0 <= '0;
        xor_p0      <= in_data;
      end

      if (data_acc)
        xor_p0 <= xor_p0 ^ in_data;

      // word_idx may wrap after the last word of a full-depth load; it is
      // not used again before the next count byte reloads it
      if (word_done) begin
        waddr_o     <= word_idx_p0;
        wdata_o     <= asm_word;
        word_idx_p0 <= word_idx_p0 + ADDR_W'(1);
        words_o     <= words_o + (ADDR_W + 1)'(1);
      end

      if (restart_ok)
        words_o <= '0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              restart_i;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [31:0]       wdata_o;
  logic              cpu_rst_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   words_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]        stream[$];
  logic [31:0]       wq[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic              exp_good;
  logic [ADDR_W-1:0] obs_addr[$];
  logic [31:0]       obs_data[$];
  logic [ADDR_W:0]   obs_words[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .restart_i (restart_i),
    .we_o      (we_o),
    .waddr_o   (waddr_o),
    .wdata_o   (wdata_o),
    .cpu_rst_o (cpu_rst_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .words_o   (words_o)
  );

  // Every cycle with we_o high is one write; a stretched pulse shows up as extras.
  always @(negedge clk) begin
    if (we_o === 1'b1) begin
      obs_addr.push_back(waddr_o);
      obs_data.push_back(wdata_o);
      obs_words.push_back(words_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: stream = count, words LSB first, XOR of everything before.
  task automatic build(input bit corrupt);
    logic [7:0] k;
    logic [7:0] cnt;
    stream.delete();
    exp_addr.delete();
    exp_data.delete();
    cnt = 8'(wq.size() - 1);
    k = cnt;
    stream.push_back(cnt);
    for (int i = 0; i < wq.size(); i++) begin
      for (int b = 0; b < 4; b++) begin
        stream.push_back(wq[i][8*b +: 8]);
        k = k ^ wq[i][8*b +: 8];
      end
      exp_addr.push_back(ADDR_W'(i));
      exp_data.push_back(wq[i]);
    end
    if (corrupt) k = k ^ 8'(1 << $urandom_range(7));
    stream.push_back(k);
    exp_good = !corrupt;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap_pct, input int restart_at, input int upto);
    for (int i = 0; i < stream.size() && i < upto; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(posedge clk);
        #1;
      end
      if (i == restart_at) begin
        restart_i = 1'b1;
        @(posedge clk);
        #1;
        restart_i = 1'b0;
      end
      send_byte(stream[i]);
    end
  endtask

  task automatic check_load(input string tag);
    int n;
    chk({tag, "_nwr"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
      chk({tag, "_data"}, 64'(obs_data[i]), 64'(exp_data[i]));
      chk({tag, "_wcnt"}, 64'(obs_words[i]), 64'(i + 1));
    end
    chk({tag, "_words"}, 64'(words_o), 64'(exp_addr.size()));
    chk({tag, "_done"}, 64'(done_o), 64'(exp_good));
    chk({tag, "_err"}, 64'(err_o), 64'(!exp_good));
    chk({tag, "_cpurst"}, 64'(cpu_rst_o), 64'(!exp_good));
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    obs_addr.delete();
    obs_data.delete();
    obs_words.delete();
  endtask

  task automatic do_restart(input string tag);
    restart_i = 1'b1;
    @(posedge clk);
    #1;
    restart_i = 1'b0;
    chk({tag, "_rs_cpurst"}, 64'(cpu_rst_o), 64'd1);
    chk({tag, "_rs_done"}, 64'(done_o), 64'd0);
    chk({tag, "_rs_err"}, 64'(err_o), 64'd0);
    chk({tag, "_rs_words"}, 64'(words_o), 64'd0);
    chk({tag, "_rs_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_we"}, 64'(we_o), 64'd0);
    chk({tag, "_waddr"}, 64'(waddr_o), 64'd0);
    chk({tag, "_wdata"}, 64'(wdata_o), 64'd0);
    chk({tag, "_cpurst"}, 64'(cpu_rst_o), 64'd1);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_words"}, 64'(words_o), 64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    restart_i = 1'b0;
    #12;
    check_reset_vals("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // single word with the documented good checksum
    stream   = '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    exp_addr = '{8'h00};
    exp_data = '{32'h12345678};
    exp_good = 1'b1;
    send_stream(0, -1, 1 << 30);
    check_load("single");
    do_restart("single");

    // same stream, wrong checksum
    stream[5] = 8'h09;
    exp_good  = 1'b0;
    send_stream(0, -1, 1 << 30);
    check_load("badck");
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk("err_hold_ready", 64'(in_ready), 64'd0);
    chk("err_hold_err", 64'(err_o), 64'd1);
    chk("err_hold_nwr", 64'(obs_addr.size()), 64'd0);
    in_valid = 1'b0;
    do_restart("badck");

    // two words with random gaps
    for (int r = 0; r < 3; r++) begin
      wq = '{$urandom(), $urandom()};
      build(1'b0);
      send_stream(40, -1, 1 << 30);
      check_load("gaps");
      do_restart("gaps");
    end

    // restart_i during DATA is ignored
    wq = '{$urandom(), $urandom(), $urandom()};
    build(1'b0);
    send_stream(20, 3, 1 << 30);
    check_load("rs_data");
    do_restart("rs_data");

    // random length with a corrupted checksum
    wq.delete();
    for (int i = 0; i < int'($urandom_range(8, 1)); i++) wq.push_back($urandom());
    build(1'b1);
    send_stream(25, -1, 1 << 30);
    check_load("rndbad");
    do_restart("rndbad");

    // asynchronous reset after six data bytes
    wq = '{$urandom(), $urandom(), $urandom(), $urandom()};
    build(1'b0);
    send_stream(0, -1, 7);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    obs_addr.delete();
    obs_data.delete();
    obs_words.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wq = '{$urandom(), $urandom(), $urandom()};
    build(1'b0);
    send_stream(10, -1, 1 << 30);
    check_load("after_rst");
    do_restart("after_rst");

    // full depth, data equals address
    wq.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) wq.push_back(32'(i));
    build(1'b0);
    send_stream(0, -1, 1 << 30);
    chk("full_lastaddr", 64'(waddr_o), 64'((1 << ADDR_W) - 1));
    check_load("full");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
